muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the MIPS execute stage. It handles MULT, MULTU, DIV and DIVU, which the single-cycle ALU cannot execute. It runs an iterative shift-add / restoring-divide datapath for SIZE cycles, owns the HI/LO registers and raises a stall request to the pipeline while an operation is in flight. The decode stage starts it with the R-type funct code; MFHI/MFLO read its outputs and MTHI/MTLO write them.

---
 rtl/muldiv_sequencer.sv | 147 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module muldiv_sequencer #(
  parameter int SIZE   = 32,
  parameter int SIZEOP = 6
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [SIZEOP-1:0] i_funct,
  input  logic [SIZE-1:0]   i_rs,
  input  logic [SIZE-1:0]   i_rt,
  input  logic              i_flush,
  input  logic              i_hi_we,
  input  logic              i_lo_we,
  input  logic [SIZE-1:0]   i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [SIZE-1:0]   o_hi,
  output logic [SIZE-1:0]   o_lo
);

  localparam int CW = $clog2(SIZE);
  localparam logic [SIZEOP-1:0] F_MULT  = SIZEOP'(24);
  localparam logic [SIZEOP-1:0] F_MULTU = SIZEOP'(25);
  localparam logic [SIZEOP-1:0] F_DIV   = SIZEOP'(26);
  localparam logic [SIZEOP-1:0] F_DIVU  = SIZEOP'(27);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*SIZE-1:0] acc_q;
  logic [SIZE-1:0]   opb_q, rs_q, hi_q, lo_q;
  logic              div_q, neg_q, remneg_q, divz_q, busy_q, done_q;

  logic              valid_op, start_ok, op_signed, op_div, rs_neg, rt_neg;
  logic [SIZE-1:0]   mag_rs, mag_rt;
  logic [SIZE:0]     mul_sum, div_up, div_diff;
  logic              div_ge;
  logic [2*SIZE-1:0] acc_calc_d, prod_fix;
  logic [SIZE-1:0]   hi_fix_d, lo_fix_d, quot, rem;

  always_comb begin
    valid_op  = (i_funct == F_MULT) || (i_funct == F_MULTU) ||
                (i_funct == F_DIV)  || (i_funct == F_DIVU);
    start_ok  = i_start && valid_op && !i_flush &&
                ((state_q == S_IDLE) || (state_q == S_DONE));
    op_signed = ~i_funct[0];
    op_div    = i_funct[1];
    rs_neg    = op_signed && i_rs[SIZE-1];
    rt_neg    = op_signed && i_rt[SIZE-1];
    mag_rs    = rs_neg ? -i_rs : i_rs;
    mag_rt    = rt_neg ? -i_rt : i_rt;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Divide: acc = {remainder, dividend bits shifting into quotient}.
    div_up   = acc_q[2*SIZE-1:SIZE-1];
    div_ge   = div_up >= {1'b0, opb_q};
    div_diff = div_up - {1'b0, opb_q};
    if (div_q)
      acc_calc_d = {div_ge ? div_diff[SIZE-1:0] : div_up[SIZE-1:0],
                    acc_q[SIZE-2:0], div_ge};
    else
      acc_calc_d = {mul_sum, acc_q[SIZE-1:1]};

    prod_fix = neg_q ? -acc_q : acc_q;
    quot     = acc_q[SIZE-1:0];
    rem      = acc_q[2*SIZE-1:SIZE];
    if (!div_q) begin
      hi_fix_d = prod_fix[2*SIZE-1:SIZE];
      lo_fix_d = prod_fix[SIZE-1:0];
    end else if (divz_q) begin
      hi_fix_d = rs_q;
      lo_fix_d = '1;
    end else begin
      hi_fix_d = remneg_q ? -rem : rem;
      lo_fix_d = neg_q ? -quot : quot;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      rs_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      remneg_q <= 1'b0;
      divz_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_CALC: begin
          if (i_flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_calc_d;
            if (cnt_q == '0) state_q <= S_FIX;
            else             cnt_q   <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!i_flush) begin
            hi_q    <= hi_fix_d;
            lo_q    <= lo_fix_d;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // MTHI/MTLO land now even when a start is accepted alongside.
          if (i_hi_we) hi_q <= i_wdata;
          if (i_lo_we) lo_q <= i_wdata;
          state_q <= S_IDLE;
          if (start_ok) begin
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
            cnt_q    <= CW'(SIZE-1);
            div_q    <= op_div;
            rs_q     <= i_rs;
            opb_q    <= op_div ? mag_rt : mag_rs;
            acc_q    <= {{SIZE{1'b0}}, op_div ? mag_rs : mag_rt};
            neg_q    <= rs_neg ^ rt_neg;
            remneg_q <= rs_neg;
            divz_q   <= op_div && (i_rt == '0);
          end
        end
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] rs = '0, rt = '0, wdata = '0;
  logic        flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, bcnt, dcnt;

  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001,
                         DIV = 6'b011010, DIVU = 6'b011011, ADDU = 6'b100001;

  always #5 clk = ~clk;

  muldiv_sequencer #(.SIZE(32), .SIZEOP(6)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_funct(funct),
    .i_rs(rs), .i_rt(rt), .i_flush(flush), .i_hi_we(hi_we), .i_lo_we(lo_we),
    .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge of cycle 1.
  task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct = f; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of the o_done cycle; lat is the cycle index.
  task automatic wait_done(output int l, output int bc);
    l = 1; bc = 0;
    while (!done && l < 200) begin
      if (busy) bc++;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); launch(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done(lat, bcnt);
    chk("multu_lat", lat, 32'd34);
    chk("multu_busy_cycles", bcnt, 32'd33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    @(negedge clk); launch(MULT, 32'hFFFFFFFD, 32'd5); wait_done(lat, bcnt);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    @(negedge clk); launch(DIV, 32'hFFFFFFF9, 32'd2); wait_done(lat, bcnt);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    @(negedge clk); launch(DIVU, 32'h64, 32'd0); wait_done(lat, bcnt);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'h00000064);

    @(negedge clk); launch(DIV, 32'h80000000, 32'hFFFFFFFF); wait_done(lat, bcnt);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h00000000);

    @(negedge clk); launch(DIV, 32'hFFFFFFF9, 32'd0); wait_done(lat, bcnt);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'hFFFFFFF9);

    // MTHI/MTLO preload, then flush a MULTU in CALC cycle 10.
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk); lo_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);
    launch(MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    lo_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk); lo_we = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy_drop", {31'd0, busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("flush_no_done", dcnt, 32'd0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h5678);

    // Back-to-back DIVU: second start issued in the DONE cycle.
    @(negedge clk); launch(DIVU, 32'd100, 32'd7); wait_done(lat, bcnt);
    chk("b2b1_busy_in_done", {31'd0, busy}, 32'd0);
    chk("b2b1_lo", lo, 32'd14);
    chk("b2b1_hi", hi, 32'd2);
    launch(DIVU, 32'hFFFFFFFF, 32'h10);
    chk("b2b2_busy_again", {31'd0, busy}, 32'd1);
    wait_done(lat, bcnt);
    chk("b2b2_lat", lat, 32'd34);
    chk("b2b2_lo", lo, 32'h0FFFFFFF);
    chk("b2b2_hi", hi, 32'h0000000F);

    @(negedge clk); launch(ADDU, 32'd1, 32'd2);
    chk("addu_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("addu_busy_later", {31'd0, busy}, 32'd0);
    chk("addu_lo_kept", lo, 32'h0FFFFFFF);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk); launch(MULTU, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); launch(MULTU, 32'd6, 32'd7); wait_done(lat, bcnt);
    chk("post_rst_lat", lat, 32'd34);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
